// File: rtl/execute_stage.sv
// LC-3 Execute stage: ALU, address adder, NZP mask and pipeline register to MemAccess/Writeback.
// Optional operand forwarding is compiled in with EXECUTE_BYPASS_EN.
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [5:0]  E_Control,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic [1:0]  W_Control_in,
  input  logic        Mem_Control_in,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
`ifdef EXECUTE_BYPASS_EN
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] Mem_Bypass_Val,
`endif
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [2:0]  dr,
  output logic [15:0] M_Data,
  output logic [2:0]  NZP,
  output logic [1:0]  W_Control_out,
  output logic        Mem_Control_out
);

  logic [15:0] r_aluout;
  logic [15:0] r_pcout;
  logic [2:0]  r_dr;
  logic [15:0] r_m_data;
  logic [2:0]  r_nzp;
  logic [1:0]  r_w_control;
  logic        r_mem_control;

  logic [1:0]  w_alu_control;
  logic [1:0]  w_pcselect1;
  logic        w_pcselect2;
  logic        w_op2select;
  logic [15:0] w_vsr1;
  logic [15:0] w_vsr2;
  logic [15:0] w_imm5;
  logic [15:0] w_off6;
  logic [15:0] w_off9;
  logic [15:0] w_off11;
  logic [15:0] w_op_b;
  logic [15:0] w_alu;
  logic [15:0] w_addend1;
  logic [15:0] w_addend2;
  logic [15:0] w_addr;
  logic [15:0] w_aluout_next;
  logic [2:0]  w_nzp_next;

  assign {w_alu_control, w_pcselect1, w_pcselect2, w_op2select} = E_Control;

  assign sr1 = IR[8:6];
  assign sr2 = (IR[13:12] == 2'b11) ? IR[11:9] : IR[2:0];

`ifdef EXECUTE_BYPASS_EN
  // ALU forwarding is the younger result, so it takes priority over MEM forwarding.
  assign w_vsr1 = bypass_alu_1 ? r_aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
  assign w_vsr2 = bypass_alu_2 ? r_aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
`else
  assign w_vsr1 = VSR1;
  assign w_vsr2 = VSR2;
`endif

  assign w_imm5  = {{11{IR[4]}}, IR[4:0]};
  assign w_off6  = {{10{IR[5]}}, IR[5:0]};
  assign w_off9  = {{7{IR[8]}},  IR[8:0]};
  assign w_off11 = {{5{IR[10]}}, IR[10:0]};

  assign w_op_b = w_op2select ? w_vsr2 : w_imm5;

  always_comb begin
    w_alu = 16'h0000;
    case (w_alu_control)
      2'd0:    w_alu = w_vsr1 + w_op_b;
      2'd1:    w_alu = w_vsr1 & w_op_b;
      2'd2:    w_alu = ~w_vsr1;
      default: w_alu = 16'h0000;
    endcase
  end

  always_comb begin
    w_addend1 = 16'h0000;
    case (w_pcselect1)
      2'd0:    w_addend1 = w_off11;
      2'd1:    w_addend1 = w_off9;
      2'd2:    w_addend1 = w_off6;
      default: w_addend1 = 16'h0000;
    endcase
  end

  assign w_addend2 = w_pcselect2 ? npc_in : w_vsr1;
  assign w_addr    = w_addend1 + w_addend2;

  // Loads and stores expose their effective address on aluout for MemAccess.
  assign w_aluout_next = (IR[13:12] == 2'b01) ? w_alu : w_addr;

  always_comb begin
    w_nzp_next = 3'b000;
    case (IR[15:12])
      4'b0000: w_nzp_next = IR[11:9];
      4'b1100: w_nzp_next = 3'b111;
      default: w_nzp_next = 3'b000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_aluout      <= 16'h0000;
      r_pcout       <= 16'h0000;
      r_dr          <= 3'b000;
      r_m_data      <= 16'h0000;
      r_nzp         <= 3'b000;
      r_w_control   <= 2'b00;
      r_mem_control <= 1'b0;
    end else if (enable_execute) begin
      r_aluout      <= w_aluout_next;
      r_pcout       <= w_addr;
      r_dr          <= IR[11:9];
      r_m_data      <= w_vsr2;
      r_nzp         <= w_nzp_next;
      r_w_control   <= W_Control_in;
      r_mem_control <= Mem_Control_in;
    end
  end

  assign aluout          = r_aluout;
  assign pcout           = r_pcout;
  assign dr              = r_dr;
  assign M_Data          = r_m_data;
  assign NZP             = r_nzp;
  assign W_Control_out   = r_w_control;
  assign Mem_Control_out = r_mem_control;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed LC-3 cases plus randomized traffic
// checked every cycle against a behavioural model (bypass cases need EXECUTE_BYPASS_EN).
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [5:0]  e_ctl;
  logic [15:0] ir;
  logic [15:0] npc;
  logic [1:0]  w_in;
  logic        m_in;
  logic [15:0] vsr1;
  logic [15:0] vsr2;
  logic        b_alu1, b_alu2, b_mem1, b_mem2;
  logic [15:0] mem_val;

  logic [2:0]  sr1, sr2, dr, nzp;
  logic [15:0] aluout, pcout, m_data;
  logic [1:0]  w_out;
  logic        m_out;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk = 1'b0;

  // Model state: what the registered outputs must hold.
  logic [15:0] x_aluout, x_pcout, x_mdata;
  logic [2:0]  x_dr, x_nzp;
  logic [1:0]  x_w;
  logic        x_m;

  execute_stage dut (
    .clock           (clk),
    .reset           (rst_n),
    .enable_execute  (en),
    .E_Control       (e_ctl),
    .IR              (ir),
    .npc_in          (npc),
    .W_Control_in    (w_in),
    .Mem_Control_in  (m_in),
    .VSR1            (vsr1),
    .VSR2            (vsr2),
`ifdef EXECUTE_BYPASS_EN
    .bypass_alu_1    (b_alu1),
    .bypass_alu_2    (b_alu2),
    .bypass_mem_1    (b_mem1),
    .bypass_mem_2    (b_mem2),
    .Mem_Bypass_Val  (mem_val),
`endif
    .sr1             (sr1),
    .sr2             (sr2),
    .aluout          (aluout),
    .pcout           (pcout),
    .dr              (dr),
    .M_Data          (m_data),
    .NZP             (nzp),
    .W_Control_out   (w_out),
    .Mem_Control_out (m_out)
  );

  always #5 clk = ~clk;

  function automatic int sx(input int v, input int bits);
    int m;
    m = v & ((1 << bits) - 1);
    if (m >= (1 << (bits - 1))) m = m - (1 << bits);
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer arithmetic straight from the instruction-set rules.
  always @(posedge clk) begin
    int a, b, opb, alu, add1, add2, addr, op;
    if (!rst_n) begin
      x_aluout = 0; x_pcout = 0; x_mdata = 0; x_dr = 0; x_nzp = 0; x_w = 0; x_m = 0;
    end else if (en) begin
      a = int'(vsr1);
      b = int'(vsr2);
`ifdef EXECUTE_BYPASS_EN
      if (b_alu1) a = int'(x_aluout); else if (b_mem1) a = int'(mem_val);
      if (b_alu2) b = int'(x_aluout); else if (b_mem2) b = int'(mem_val);
`endif
      opb = e_ctl[0] ? b : sx(int'(ir), 5);
      case (int'(e_ctl[5:4]))
        0: alu = a + opb;
        1: alu = a & opb;
        2: alu = ~a;
        default: alu = 0;
      endcase
      case (int'(e_ctl[3:2]))
        0: add1 = sx(int'(ir), 11);
        1: add1 = sx(int'(ir), 9);
        2: add1 = sx(int'(ir), 6);
        default: add1 = 0;
      endcase
      add2 = e_ctl[1] ? int'(npc) : a;
      addr = (add1 + add2) & 16'hFFFF;
      op = int'(ir[15:12]);
      x_pcout  = addr[15:0];
      x_aluout = (op == 1 || op == 5 || op == 9 || op == 13) ? alu[15:0] : addr[15:0];
      x_nzp    = (op == 0) ? ir[11:9] : ((op == 12) ? 3'b111 : 3'b000);
      x_dr     = ir[11:9];
      x_mdata  = b[15:0];
      x_w      = w_in;
      x_m      = m_in;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("aluout", int'(aluout), int'(x_aluout));
      check("pcout", int'(pcout), int'(x_pcout));
      check("M_Data", int'(m_data), int'(x_mdata));
      check("dr", int'(dr), int'(x_dr));
      check("NZP", int'(nzp), int'(x_nzp));
      check("W_Control_out", int'(w_out), int'(x_w));
      check("Mem_Control_out", int'(m_out), int'(x_m));
      check("sr1", int'(sr1), int'(ir[8:6]));
      check("sr2", int'(sr2), (ir[13] && ir[12]) ? int'(ir[11:9]) : int'(ir[2:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [15:0] i, input logic [5:0] e, input logic [15:0] n,
                       input logic [15:0] v1, input logic [15:0] v2);
    ir = i; e_ctl = e; npc = n; vsr1 = v1; vsr2 = v2;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1;
    drive(16'h1662, 6'b010101, 16'h1234, 16'hAAAA, 16'h5555);
    w_in = 2'b11; m_in = 1'b1;
    b_alu1 = 0; b_alu2 = 0; b_mem1 = 0; b_mem2 = 0; mem_val = 16'h0000;
    step();
    chk = 1'b1;
    step();
    check("rst_aluout", int'(aluout), 0);
    check("rst_pcout", int'(pcout), 0);
    check("rst_mdata", int'(m_data), 0);
    check("rst_nzp", int'(nzp), 0);
    check("rst_w", int'(w_out), 0);
    check("rst_m", int'(m_out), 0);

    rst_n = 1'b1; w_in = 2'b01; m_in = 1'b0;
    // ADD R3,R1,#-2
    drive(16'h167E, 6'b000000, 16'h3000, 16'h0001, 16'h0000);
    #1;
    check("add_sr1", int'(sr1), 1);
    check("add_sr2", int'(sr2), 6);
    step();
    check("add_aluout", int'(aluout), 16'hFFFF);
    check("add_dr", int'(dr), 3);
    check("add_nzp", int'(nzp), 0);
    check("add_w", int'(w_out), 1);

    // BRnzp #-1
    drive(16'h0FFF, 6'b000110, 16'h3001, 16'h0000, 16'h0000);
    step();
    check("br_pcout", int'(pcout), 16'h3000);
    check("br_nzp", int'(nzp), 7);

    // JMP R2
    drive(16'hC080, 6'b001100, 16'h3002, 16'h4000, 16'h0000);
    step();
    check("jmp_pcout", int'(pcout), 16'h4000);
    check("jmp_nzp", int'(nzp), 7);

    // STR R4,R5,#3
    drive(16'h7943, 6'b001000, 16'h3003, 16'h0010, 16'hBEEF);
    #1;
    check("str_sr2", int'(sr2), 4);
    step();
    check("str_aluout", int'(aluout), 16'h0013);
    check("str_pcout", int'(pcout), 16'h0013);
    check("str_mdata", int'(m_data), 16'hBEEF);

    // Hold for three cycles, then advance once: AND R0,R1,R2
    en = 1'b0;
    drive(16'h5042, 6'b010001, 16'h3004, 16'hF0F0, 16'hFF00);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_aluout", int'(aluout), 16'h0013);
    end
    en = 1'b1;
    step();
    en = 1'b0;
    check("adv_aluout", int'(aluout), 16'hF000);
    step();
    check("adv_once_aluout", int'(aluout), 16'hF000);
    en = 1'b1;

    // Address-adder wrap: LEA with npc=FFFF, offset9=+1
    drive(16'hE001, 6'b000110, 16'hFFFF, 16'h0000, 16'h0000);
    step();
    check("wrap_pcout", int'(pcout), 16'h0000);

`ifdef EXECUTE_BYPASS_EN
    drive(16'h1260, 6'b000000, 16'h3005, 16'h0F0F, 16'h0000);
    step();
    check("byp_prev", int'(aluout), 16'h0F0F);
    drive(16'h5242, 6'b010001, 16'h3006, 16'h1234, 16'h00FF);
    mem_val = 16'hF0F0; b_alu1 = 1; b_mem1 = 1;
    step();
    check("byp_and", int'(aluout), 16'h000F);
    b_alu1 = 0; b_mem1 = 0;
`endif

    for (int k = 0; k < 400; k++) begin
      drive(16'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      w_in = 2'($urandom); m_in = 1'($urandom);
      en = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 31) != 0);
`ifdef EXECUTE_BYPASS_EN
      b_alu1 = 1'($urandom); b_alu2 = 1'($urandom);
      b_mem1 = 1'($urandom); b_mem2 = 1'($urandom);
      mem_val = 16'($urandom);
`endif
      step();
    end
    rst_n = 1'b1;
    step();
    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
